// File: rtl/decode_queue_pkg.sv
// rtl/decode_queue_pkg.sv - op codes, field widths and decoded bundle type for decode_queue
package decode_queue_pkg;

  localparam int OP_W  = 6;
  localparam int REG_W = 5;
  localparam int IMM_W = 32;

  typedef logic [OP_W-1:0]  op_t;
  typedef logic [REG_W-1:0] reg_id_t;
  typedef logic [IMM_W-1:0] imm_t;

  localparam op_t NOP_INST   = 6'd0;
  localparam op_t LUI_INST   = 6'd1;
  localparam op_t AUIPC_INST = 6'd2;
  localparam op_t JAL_INST   = 6'd3;
  localparam op_t JALR_INST  = 6'd4;
  localparam op_t BEQ_INST   = 6'd5;
  localparam op_t BNE_INST   = 6'd6;
  localparam op_t BLT_INST   = 6'd7;
  localparam op_t BGE_INST   = 6'd8;
  localparam op_t BLTU_INST  = 6'd9;
  localparam op_t BGEU_INST  = 6'd10;
  localparam op_t LB_INST    = 6'd11;
  localparam op_t LH_INST    = 6'd12;
  localparam op_t LW_INST    = 6'd13;
  localparam op_t LBU_INST   = 6'd14;
  localparam op_t LHU_INST   = 6'd15;
  localparam op_t SB_INST    = 6'd16;
  localparam op_t SH_INST    = 6'd17;
  localparam op_t SW_INST    = 6'd18;
  localparam op_t ADDI_INST  = 6'd19;
  localparam op_t SLTI_INST  = 6'd20;
  localparam op_t SLTIU_INST = 6'd21;
  localparam op_t XORI_INST  = 6'd22;
  localparam op_t ORI_INST   = 6'd23;
  localparam op_t ANDI_INST  = 6'd24;
  localparam op_t SLLI_INST  = 6'd25;
  localparam op_t SRLI_INST  = 6'd26;
  localparam op_t SRAI_INST  = 6'd27;
  localparam op_t ADD_INST   = 6'd28;
  localparam op_t SUB_INST   = 6'd29;
  localparam op_t SLL_INST   = 6'd30;
  localparam op_t SLT_INST   = 6'd31;
  localparam op_t SLTU_INST  = 6'd32;
  localparam op_t XOR_INST   = 6'd33;
  localparam op_t SRL_INST   = 6'd34;
  localparam op_t SRA_INST   = 6'd35;
  localparam op_t OR_INST    = 6'd36;
  localparam op_t AND_INST   = 6'd37;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    op_t     op;
    reg_id_t rd;
    reg_id_t rs1;
    reg_id_t rs2;
    imm_t    imm;
    logic    is_load_or_store;
    logic    is_store;
    logic    is_branch;
    logic    illegal;
  } decoded_t;

  // Bundle with every field cleared and op forced to NOP_INST
  function automatic decoded_t nop_bundle();
    decoded_t b;
    b    = '0;
    b.op = NOP_INST;
    return b;
  endfunction

endpackage

// File: rtl/decode_queue_if.sv
// rtl/decode_queue_if.sv - fetch-side and dispatch-side handshake bundle for decode_queue
interface decode_queue_if;

  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_pc;
  logic [31:0]              in_inst;

  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_pc;
  decode_queue_pkg::op_t     out_op;
  decode_queue_pkg::reg_id_t out_rd;
  decode_queue_pkg::reg_id_t out_rs1;
  decode_queue_pkg::reg_id_t out_rs2;
  decode_queue_pkg::imm_t    out_imm;
  logic                     out_is_load_or_store;
  logic                     out_is_store;
  logic                     out_is_branch;
  logic                     out_illegal;

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2, out_imm,
           out_is_load_or_store, out_is_store, out_is_branch, out_illegal
  );

  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2, out_imm,
           out_is_load_or_store, out_is_store, out_is_branch, out_illegal
  );

endinterface

// File: rtl/decode_queue_decode_logic.sv
// rtl/decode_queue_decode_logic.sv - combinational RV32I decode of one raw instruction
module decode_logic
  import decode_queue_pkg::*;
(
  input  logic [31:0] inst,
  output decoded_t    dec
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic        ok;
  decoded_t    d;

  assign opc    = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_sh = {27'b0, inst[24:20]};

  // Full opcode match also rejects inst[1:0] != 2'b11; any illegal case collapses to a NOP bundle
  always_comb begin
    ok = 1'b1;
    d  = nop_bundle();
    case (opc)
      OPC_LUI:   begin d.op = LUI_INST;   d.rd = inst[11:7]; d.imm = imm_u; end
      OPC_AUIPC: begin d.op = AUIPC_INST; d.rd = inst[11:7]; d.imm = imm_u; end
      OPC_JAL: begin
        d.op = JAL_INST; d.rd = inst[11:7]; d.imm = imm_j; d.is_branch = 1'b1;
      end
      OPC_JALR: begin
        d.op = JALR_INST; d.rd = inst[11:7]; d.rs1 = inst[19:15]; d.imm = imm_i;
        d.is_branch = 1'b1;
        ok = (f3 == 3'b000);
      end
      OPC_BRANCH: begin
        d.rs1 = inst[19:15]; d.rs2 = inst[24:20]; d.imm = imm_b; d.is_branch = 1'b1;
        case (f3)
          3'b000:  d.op = BEQ_INST;
          3'b001:  d.op = BNE_INST;
          3'b100:  d.op = BLT_INST;
          3'b101:  d.op = BGE_INST;
          3'b110:  d.op = BLTU_INST;
          3'b111:  d.op = BGEU_INST;
          default: ok = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        d.rd = inst[11:7]; d.rs1 = inst[19:15]; d.imm = imm_i; d.is_load_or_store = 1'b1;
        case (f3)
          3'b000:  d.op = LB_INST;
          3'b001:  d.op = LH_INST;
          3'b010:  d.op = LW_INST;
          3'b100:  d.op = LBU_INST;
          3'b101:  d.op = LHU_INST;
          default: ok = 1'b0;
        endcase
      end
      OPC_STORE: begin
        d.rs1 = inst[19:15]; d.rs2 = inst[24:20]; d.imm = imm_s;
        d.is_load_or_store = 1'b1; d.is_store = 1'b1;
        case (f3)
          3'b000:  d.op = SB_INST;
          3'b001:  d.op = SH_INST;
          3'b010:  d.op = SW_INST;
          default: ok = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        d.rd = inst[11:7]; d.rs1 = inst[19:15]; d.imm = imm_i;
        case (f3)
          3'b000: d.op = ADDI_INST;
          3'b010: d.op = SLTI_INST;
          3'b011: d.op = SLTIU_INST;
          3'b100: d.op = XORI_INST;
          3'b110: d.op = ORI_INST;
          3'b111: d.op = ANDI_INST;
          3'b001: begin d.op = SLLI_INST; d.imm = imm_sh; ok = (f7 == 7'b0000000); end
          default: begin
            d.imm = imm_sh;
            if (f7 == 7'b0000000)      d.op = SRLI_INST;
            else if (f7 == 7'b0100000) d.op = SRAI_INST;
            else                       ok = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        d.rd = inst[11:7]; d.rs1 = inst[19:15]; d.rs2 = inst[24:20];
        case ({f7, f3})
          {7'b0000000, 3'b000}: d.op = ADD_INST;
          {7'b0100000, 3'b000}: d.op = SUB_INST;
          {7'b0000000, 3'b001}: d.op = SLL_INST;
          {7'b0000000, 3'b010}: d.op = SLT_INST;
          {7'b0000000, 3'b011}: d.op = SLTU_INST;
          {7'b0000000, 3'b100}: d.op = XOR_INST;
          {7'b0000000, 3'b101}: d.op = SRL_INST;
          {7'b0100000, 3'b101}: d.op = SRA_INST;
          {7'b0000000, 3'b110}: d.op = OR_INST;
          {7'b0000000, 3'b111}: d.op = AND_INST;
          default:              ok = 1'b0;
        endcase
      end
      default: ok = 1'b0;
    endcase
    dec = d;
    if (!ok) begin
      dec         = nop_bundle();
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - raw-instruction FIFO with a registered decoded output stage
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  decode_queue_if.slave    q,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             push, load;
  logic             out_valid_q;
  logic [31:0]      out_pc_q;
  decoded_t         head_dec, out_q;

  assign q.in_ready = (count < CNT_W'(DEPTH));
  assign push       = rdy_in && q.in_valid && q.in_ready;
  assign load       = rdy_in && (count != '0) && (!out_valid_q || q.out_ready);

  decode_logic u_decode_logic (
    .inst (inst_mem[rd_ptr]),
    .dec  (head_dec)
  );

  // Storage write; a push under flush lands in a slot the pointer reset abandons
  always_ff @(posedge clk_in) begin
    if (push) begin
      pc_mem[wr_ptr]   <= q.in_pc;
      inst_mem[wr_ptr] <= q.in_inst;
    end
  end

  // Pointers and occupancy; load is the FIFO pop
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (load) rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !load)      count <= count + CNT_W'(1);
        else if (!push && load) count <= count - CNT_W'(1);
      end
    end
  end

  // Output stage: take the decoded head when free or being consumed, else hold
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_q       <= nop_bundle();
    end else if (rdy_in) begin
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (load) begin
        out_valid_q <= 1'b1;
        out_pc_q    <= pc_mem[rd_ptr];
        out_q       <= head_dec;
      end else if (q.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign q.out_valid            = out_valid_q;
  assign q.out_pc               = out_pc_q;
  assign q.out_op               = out_q.op;
  assign q.out_rd               = out_q.rd;
  assign q.out_rs1              = out_q.rs1;
  assign q.out_rs2              = out_q.rs2;
  assign q.out_imm              = out_q.imm;
  assign q.out_is_load_or_store = out_q.is_load_or_store;
  assign q.out_is_store         = out_q.is_store;
  assign q.out_is_branch        = out_q.is_branch;
  assign q.out_illegal          = out_q.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - directed self-checking bench for decode_queue
module tb_decode_queue;
  import decode_queue_pkg::*;

  logic       clk = 1'b0;
  logic       rst_in, rdy_in, flush;
  logic [2:0] count;
  int         checks = 0;
  int         errors = 0;

  decode_queue_if bus ();

  decode_queue #(.DEPTH(4)) dut (
    .clk_in (clk),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .q      (bus),
    .count  (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wait(input logic [31:0] pc, input logic [31:0] inst);
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_inst  = inst;
    tick();
    bus.in_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst_in        = 1'b1;
    rdy_in        = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_inst   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();

    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_op", 32'(bus.out_op), 32'(NOP_INST));
    chk("rst_pc", bus.out_pc, 32'd0);
    chk("rst_imm", bus.out_imm, 32'd0);
    chk("rst_illegal", 32'(bus.out_illegal), 32'd0);

    rst_in = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // ADDI x1, x0, 5 with two-cycle latency
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h100;
    bus.in_inst   = 32'h00500093;
    tick();
    bus.in_valid = 1'b0;
    chk("addi_lat1_valid", 32'(bus.out_valid), 32'd0);
    chk("addi_lat1_count", 32'(count), 32'd1);
    tick();
    chk("addi_valid", 32'(bus.out_valid), 32'd1);
    chk("addi_op", 32'(bus.out_op), 32'(ADDI_INST));
    chk("addi_rd", 32'(bus.out_rd), 32'd1);
    chk("addi_rs1", 32'(bus.out_rs1), 32'd0);
    chk("addi_imm", bus.out_imm, 32'd5);
    chk("addi_pc", bus.out_pc, 32'h100);
    chk("addi_count", 32'(count), 32'd0);
    tick();
    chk("drain_valid", 32'(bus.out_valid), 32'd0);

    push_wait(32'h104, 32'h4030D113);
    chk("srai_op", 32'(bus.out_op), 32'(SRAI_INST));
    chk("srai_rd", 32'(bus.out_rd), 32'd2);
    chk("srai_rs1", 32'(bus.out_rs1), 32'd1);
    chk("srai_imm", bus.out_imm, 32'd3);
    chk("srai_illegal", 32'(bus.out_illegal), 32'd0);

    push_wait(32'h108, 32'hFFC08067);
    chk("jalr_op", 32'(bus.out_op), 32'(JALR_INST));
    chk("jalr_rd", 32'(bus.out_rd), 32'd0);
    chk("jalr_rs1", 32'(bus.out_rs1), 32'd1);
    chk("jalr_imm", bus.out_imm, 32'hFFFFFFFC);
    chk("jalr_branch", 32'(bus.out_is_branch), 32'd1);
    chk("jalr_ls", 32'(bus.out_is_load_or_store), 32'd0);

    // SW x5, 8(x2)
    push_wait(32'h10C, 32'h00512423);
    chk("sw_op", 32'(bus.out_op), 32'(SW_INST));
    chk("sw_rs1", 32'(bus.out_rs1), 32'd2);
    chk("sw_rs2", 32'(bus.out_rs2), 32'd5);
    chk("sw_imm", bus.out_imm, 32'd8);
    chk("sw_store", 32'(bus.out_is_store), 32'd1);
    chk("sw_ls", 32'(bus.out_is_load_or_store), 32'd1);
    chk("sw_branch", 32'(bus.out_is_branch), 32'd0);

    // LUI x1, 0x12345
    push_wait(32'h110, 32'h123450B7);
    chk("lui_op", 32'(bus.out_op), 32'(LUI_INST));
    chk("lui_rd", 32'(bus.out_rd), 32'd1);
    chk("lui_imm", bus.out_imm, 32'h12345000);

    // Fill: six offers with the output blocked, five fit
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_pc    = 32'h200 + 32'(4 * i);
      bus.in_inst  = 32'h00000093 | (32'(i) << 20);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_out_valid", 32'(bus.out_valid), 32'd1);
    chk("full_out_pc", bus.out_pc, 32'h200);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("pop_count", 32'(count), 32'd3);
    chk("pop_out_valid", 32'(bus.out_valid), 32'd1);
    chk("pop_out_pc", bus.out_pc, 32'h204);
    chk("pop_out_imm", bus.out_imm, 32'd1);

    // Refill to full, then flush with an instruction on offer
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h300;
    bus.in_inst  = 32'h00300093;
    tick();
    chk("refill_count", 32'(count), 32'd4);
    flush        = 1'b1;
    bus.in_pc    = 32'h400;
    bus.in_inst  = 32'h00700093;
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_no_output", 32'(bus.out_valid), 32'd0);
    end

    // Illegal instruction at the output, one entry queued behind it
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h500;
    bus.in_inst   = 32'h00000000;
    tick();
    bus.in_pc     = 32'h504;
    bus.in_inst   = 32'h00900093;
    tick();
    bus.in_valid  = 1'b0;
    chk("ill_valid", 32'(bus.out_valid), 32'd1);
    chk("ill_illegal", 32'(bus.out_illegal), 32'd1);
    chk("ill_op", 32'(bus.out_op), 32'(NOP_INST));
    chk("ill_rd", 32'(bus.out_rd), 32'd0);
    chk("ill_imm", bus.out_imm, 32'd0);
    chk("ill_pc", bus.out_pc, 32'h500);
    chk("ill_count", 32'(count), 32'd1);

    // Global enable low: pushes, pops and flush all ignored
    rdy_in        = 1'b0;
    flush         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h600;
    bus.in_inst   = 32'h00100093;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_count", 32'(count), 32'd1);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_pc", bus.out_pc, 32'h500);
      chk("hold_illegal", 32'(bus.out_illegal), 32'd1);
    end
    rdy_in       = 1'b1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    chk("resume_pc", bus.out_pc, 32'h504);
    chk("resume_imm", bus.out_imm, 32'd9);
    chk("resume_illegal", 32'(bus.out_illegal), 32'd0);
    chk("resume_count", 32'(count), 32'd0);

    // Reset mid-operation drops everything
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h700;
    bus.in_inst   = 32'h00200093;
    tick();
    tick();
    bus.in_valid = 1'b0;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_op", 32'(bus.out_op), 32'(NOP_INST));
    chk("midrst_pc", bus.out_pc, 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("midrst_empty", 32'(bus.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
